// File: rtl/packet_replay_fifo.sv
// packet_replay_fifo: stop-and-wait replay buffer for an egress framed stream.
// Each packet is sent once, then held until ack_i releases it or redo_i
// rewinds the read pointer to its first word for a resend.
//
// Handshake rules: a word moves across an interface on a rising edge where
// both valid and ready are high. valid_o/last_o/data_o hold steady while
// valid_o && !ready_i, unless redo_i rewinds the read pointer. ready_o and
// valid_o depend on registers only, never on same-cycle inputs.
module packet_replay_fifo #(
    parameter int WIDTH = 8,
    parameter int ABITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    output logic [ABITS:0]   level_o,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             last_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ack_i,
    input  logic             redo_i,
    output logic             wait_o,
    output logic [3:0]       tries_o
);

    localparam int DEPTH = 2 ** ABITS;
    localparam logic [ABITS:0] FULL_LEVEL = {1'b1, {ABITS{1'b0}}};

    typedef enum logic {
        ST_SEND = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // {last, data} per word
    logic [WIDTH:0] mem_q [DEPTH];

    state_e         state_q;
    logic [ABITS:0] waddr_q;
    logic [ABITS:0] raddr_q;
    logic [ABITS:0] caddr_q;
    logic [3:0]     tries_q;

    logic           wr_en;
    logic           rd_en;
    logic [ABITS:0] waddr_d;
    logic [3:0]     tries_d;

    // Output decode and next-value helpers; all outputs come from registers.
    always_comb begin
        level_o  = waddr_q - caddr_q;
        ready_o  = (level_o != FULL_LEVEL);
        valid_o  = (state_q == ST_SEND) && (raddr_q != waddr_q);
        wait_o   = (state_q == ST_WAIT);
        tries_o  = tries_q;
        {last_o, data_o} = mem_q[raddr_q[ABITS-1:0]];
        wr_en    = valid_i && ready_o;
        rd_en    = valid_o && ready_i;
        waddr_d  = wr_en ? waddr_q + 1'b1 : waddr_q;
        tries_d  = (tries_q == 4'hF) ? tries_q : tries_q + 4'd1;
    end

    // Storage write; contents need no reset because pointers gate every read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[waddr_q[ABITS-1:0]] <= {last_i, data_i};
        end
    end

    // Write pointer runs independently of the send/wait state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            waddr_q <= '0;
        end else begin
            waddr_q <= waddr_d;
        end
    end

    // Send/wait FSM owning the read pointer, commit pointer and retry count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SEND;
            raddr_q <= '0;
            caddr_q <= '0;
            tries_q <= '0;
        end else begin
            case (state_q)
                ST_SEND: begin
                    // A rewind beats any transfer in the same cycle.
                    if (redo_i) begin
                        raddr_q <= caddr_q;
                        tries_q <= tries_d;
                    end else if (rd_en) begin
                        raddr_q <= raddr_q + 1'b1;
                        if (last_o) begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // ack wins over a simultaneous redo.
                    if (ack_i) begin
                        caddr_q <= raddr_q;
                        tries_q <= '0;
                        state_q <= ST_SEND;
                    end else if (redo_i) begin
                        raddr_q <= caddr_q;
                        tries_q <= tries_d;
                        state_q <= ST_SEND;
                    end
                end
                default: state_q <= ST_SEND;
            endcase
        end
    end

endmodule
